// File: rtl/wwvb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wwvb_pkg
// Description : Shared types and constants for the WWVB timing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package wwvb_pkg;

    // Symbol carried by one timeframe cell
    typedef enum logic [1:0] {
        CV_ZERO = 2'b00,
        CV_ONE  = 2'b01,
        CV_REF  = 2'b10,
        CV_RSVD = 2'b11
    } t_cell_value;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } t_seq_state;

    localparam int FRAME_LEN   = 60;
    localparam int MS_PER_SEC  = 1000;
    localparam int LOW_MS_ZERO = 200;
    localparam int LOW_MS_ONE  = 500;
    localparam int LOW_MS_REF  = 800;

    // Reduced-power duration in ms for a cell symbol; the unused code is
    // treated like a marker so a corrupted cell never shortens the envelope
    function automatic logic [9:0] low_duration(input t_cell_value cv);
        case (cv)
            CV_ZERO: low_duration = 10'(LOW_MS_ZERO);
            CV_ONE:  low_duration = 10'(LOW_MS_ONE);
            default: low_duration = 10'(LOW_MS_REF);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wwvb_ms_tick.sv
`default_nettype none
// ============================================================================
// Module      : wwvb_ms_tick
// Description : Millisecond prescaler. Counts 0..CLK_PERIOD/1000-1 and flags
//               the terminal count; held at zero while clear is high.
// Revision    : 1.0 - initial release
// ============================================================================
module wwvb_ms_tick #(
    parameter int CLK_PERIOD = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic ms_tick
);

    localparam int                 c_DIV      = CLK_PERIOD / 1000;
    localparam int                 c_CNT_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TERMINAL = c_CNT_W'(c_DIV - 1);

    logic [c_CNT_W-1:0] r_count;

    // Free-running divider, restarted from zero whenever clear is asserted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || (r_count == c_TERMINAL)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign ms_tick = !clear && (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/wwvb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wwvb_frame_sequencer
// Description : Second/frame sequencer for the WWVB timeframe. Issues the
//               per-second clock enable and frame-boundary load, and drives
//               the reduced-power envelope from the head cell symbol.
// Revision    : 1.0 - initial release
// ============================================================================
module wwvb_frame_sequencer
    import wwvb_pkg::*;
#(
    parameter int CLK_PERIOD = 100_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  t_cell_value cell_value,
    input  logic        update_req,
    output logic        sec_tick,
    output logic        load,
    output logic        update_ack,
    output logic        power_low,
    output logic [5:0]  second_index,
    output logic        frame_start
);

    localparam logic [9:0] c_MS_LAST  = 10'(MS_PER_SEC - 1);
    localparam logic [5:0] c_SEC_LAST = 6'(FRAME_LEN - 1);

    t_seq_state r_state;
    logic [9:0] r_ms;
    logic [9:0] r_low_ms;
    logic       r_pending;
    logic       r_first;   // first cycle of a second (envelope just rose)
    logic       r_sample;  // head cell is stable: capture its duration

    logic       w_clear;
    logic       w_ms_tick;
    logic       w_sec_end;
    logic       w_frame_end;
    logic [9:0] w_ms_next;

    // Prescaler only runs in RUN, so every second starts at prescaler zero
    assign w_clear = (r_state != RUN) || !enable;

    wwvb_ms_tick #(
        .CLK_PERIOD (CLK_PERIOD)
    ) u_ms_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .ms_tick (w_ms_tick)
    );

    assign w_sec_end   = w_ms_tick && (r_ms == c_MS_LAST);
    assign w_frame_end = w_sec_end && (second_index == c_SEC_LAST);
    assign w_ms_next   = w_sec_end ? 10'd0 : (r_ms + 10'd1);

    // Staged-update flag; the acknowledge cycle wins over a coincident request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (update_ack) begin
            r_pending <= 1'b0;
        end else if (update_req) begin
            r_pending <= 1'b1;
        end
    end

    // Sequencer FSM with registered pulse and envelope outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ms         <= '0;
            r_low_ms     <= '0;
            r_first      <= 1'b0;
            r_sample     <= 1'b0;
            sec_tick     <= 1'b0;
            load         <= 1'b0;
            update_ack   <= 1'b0;
            power_low    <= 1'b0;
            second_index <= '0;
            frame_start  <= 1'b0;
        end else begin
            sec_tick    <= 1'b0;
            load        <= 1'b0;
            update_ack  <= 1'b0;
            frame_start <= 1'b0;
            if (!enable) begin
                r_state      <= IDLE;
                r_ms         <= '0;
                r_first      <= 1'b0;
                r_sample     <= 1'b0;
                power_low    <= 1'b0;
                second_index <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // Realign the timeframe head and hand over staged data
                        r_state    <= START;
                        sec_tick   <= 1'b1;
                        load       <= 1'b1;
                        update_ack <= r_pending;
                    end
                    START: begin
                        r_state      <= RUN;
                        r_ms         <= '0;
                        second_index <= '0;
                        frame_start  <= 1'b1;
                        power_low    <= 1'b1;
                        r_first      <= 1'b1;
                    end
                    RUN: begin
                        r_first  <= 1'b0;
                        r_sample <= r_first;
                        // The head shifts on the sec_tick edge, so the cell is
                        // read one cycle after the envelope rises
                        if (r_sample) begin
                            r_low_ms <= low_duration(cell_value);
                        end
                        if (w_ms_tick) begin
                            r_ms <= w_ms_next;
                        end
                        if (w_sec_end) begin
                            sec_tick     <= 1'b1;
                            power_low    <= 1'b1;
                            r_first      <= 1'b1;
                            second_index <= w_frame_end ? 6'd0 : (second_index + 6'd1);
                            frame_start  <= w_frame_end;
                            load         <= w_frame_end && r_pending;
                            update_ack   <= w_frame_end && r_pending;
                        end else if (w_ms_tick && (w_ms_next == r_low_ms)) begin
                            power_low <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wwvb_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_wwvb_frame_sequencer
// Description : Scoreboard bench for wwvb_frame_sequencer. Stimulus queues the
//               expected output events with their cycle numbers; a monitor
//               pops and compares whenever the DUT shows any output activity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wwvb_frame_sequencer;
    import wwvb_pkg::*;

    // Two clocks per millisecond keeps multi-frame runs short
    localparam int CLK_PERIOD = 2000;
    localparam int P          = CLK_PERIOD / 1000;
    localparam int SEC        = CLK_PERIOD;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b0;
    logic        update_req = 1'b0;
    t_cell_value cell_value = CV_ZERO;
    logic        sec_tick;
    logic        load;
    logic        update_ack;
    logic        power_low;
    logic [5:0]  second_index;
    logic        frame_start;

    wwvb_frame_sequencer #(
        .CLK_PERIOD (CLK_PERIOD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cell_value   (cell_value),
        .update_req   (update_req),
        .sec_tick     (sec_tick),
        .load         (load),
        .update_ack   (update_ack),
        .power_low    (power_low),
        .second_index (second_index),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       st;
        logic       ld;
        logic       ak;
        logic       fs;
        logic       pl;
        logic [5:0] si;
    } t_ev;

    t_ev         exp_q[$];
    t_ev         want;
    int          checks  = 0;
    int          errors  = 0;
    logic        probe   = 1'b0;
    logic        mon_en  = 1'b0;
    logic        prev_pl = 1'b0;
    logic [5:0]  prev_si = 6'd0;
    bit          pend    = 1'b0;

    t_cell_value cv_tbl [4] = '{CV_ZERO, CV_ONE, CV_REF, CV_RSVD};
    int          ms_tbl [4] = '{200, 500, 800, 800};

    // Monitor: any output activity is one event to be matched
    always @(negedge clk) begin
        if (mon_en && (probe || sec_tick || load || update_ack || frame_start ||
                       (power_low !== prev_pl) || (second_index !== prev_si))) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d st=%b ld=%b ak=%b fs=%b pl=%b si=%0d, none expected",
                         cyc, sec_tick, load, update_ack, frame_start, power_low, second_index);
            end else begin
                want = exp_q.pop_front();
                if ((want.c != cyc) ||
                    ({want.st, want.ld, want.ak, want.fs, want.pl, want.si} !==
                     {sec_tick, load, update_ack, frame_start, power_low, second_index})) begin
                    errors++;
                    $display("FAIL event%0d: got cyc=%0d st=%b ld=%b ak=%b fs=%b pl=%b si=%0d, expected cyc=%0d st=%b ld=%b ak=%b fs=%b pl=%b si=%0d",
                             checks, cyc, sec_tick, load, update_ack, frame_start, power_low, second_index,
                             want.c, want.st, want.ld, want.ak, want.fs, want.pl, want.si);
                end
            end
        end
        prev_pl = power_low;
        prev_si = second_index;
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic st, input logic ld, input logic ak,
                        input logic fs, input logic pl, input int si);
        t_ev e;
        e.c  = c;
        e.st = st;
        e.ld = ld;
        e.ak = ak;
        e.fs = fs;
        e.pl = pl;
        e.si = 6'(si);
        exp_q.push_back(e);
    endtask

    task automatic probe_idle(input int c);
        goto(c);
        push(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        probe = 1'b1;
        goto(c + 1);
        probe = 1'b0;
    endtask

    // One enable epoch: enable rises at cycle e, seconds 0..last run, and the
    // last second is cut `cut` cycles in, by reset or by dropping enable.
    // update_req pulses in second req_sec and in the cycle of the frame-60 load.
    task automatic run_epoch(input int e, input int last, input int cut,
                             input bit by_reset, input int req_sec);
        int s0;
        int sn;
        bit wrap;
        s0 = e + 2;
        goto(e);
        push(e + 1, 1'b1, 1'b1, pend, 1'b0, 1'b0, 0);
        push(s0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        pend   = 1'b0;
        enable = 1'b1;
        for (int n = 0; n <= last; n++) begin
            sn = s0 + n * SEC;
            if (n > 0) begin
                wrap = (n % 60 == 0);
                push(sn, 1'b1, wrap && pend, wrap && pend, wrap, 1'b1, n % 60);
                if (wrap) pend = 1'b0;
            end
            if (n != last) push(sn + ms_tbl[n % 4] * P, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n % 60);
            goto(sn);
            if (n == 60) update_req = 1'b1;
            goto(sn + 1);
            update_req = 1'b0;
            cell_value = cv_tbl[n % 4];
            if (n == req_sec) begin
                update_req = 1'b1;
                goto(sn + 2);
                update_req = 1'b0;
                pend = 1'b1;
            end
            if (n != last) goto(sn + SEC - 1);
        end
        sn = s0 + last * SEC;
        goto(sn + cut);
        if (by_reset) begin
            push(sn + cut, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            reset_n = 1'b0;
            enable  = 1'b0;
            pend    = 1'b0;
        end else begin
            push(sn + cut + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            enable = 1'b0;
        end
    endtask

    initial begin
        int k;
        goto(2);
        mon_en = 1'b1;
        probe_idle(2);
        reset_n = 1'b1;
        probe_idle(6);

        // Epoch 1: request in second 5, enable dropped at second 17 ms 300
        run_epoch(10, 17, 300 * P, 1'b0, 5);
        k = cyc;
        probe_idle(k + 3);

        // Epoch 2: pending acked at START, request at 30, two frame wraps,
        // reset while the envelope is low-power
        run_epoch(k + 6, 120, 50, 1'b1, 30);
        k = cyc;
        goto(k + 3);
        reset_n = 1'b1;
        probe_idle(k + 8);

        // After reset: restart only on enable, nothing left pending
        goto(k + 10);
        push(k + 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        push(k + 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        enable = 1'b1;
        goto(k + 16);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, first at cyc=%0d",
                     exp_q.size(), exp_q[0].c);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #6_000_000;
        $display("FAIL watchdog: cyc=%0d, run did not complete", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
